hazard_scheduler: RTL and testbench

- Pipeline sequencing controller for the 5-stage MIPS core.
- Issues per-stage enables, flushes and bubbles to PC, IF/ID, ID/EX, EX/MEM and MEM/WB.
- Detects load-use and ID-stage branch/jr operand hazards, squashes wrong-path fetches after taken control transfers, and freezes the pipe during multi-cycle data-memory accesses.
- Includes a watchdog on memory wait.

---
 rtl/hazard_scheduler.sv | 175 +++++++++++++++++
 tb/tb_hazard_scheduler.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_scheduler.sv
// rtl/hazard_scheduler.sv - pipeline hazard/stall/flush sequencer with memory-wait watchdog (optional perf counters: HAZARD_PERF_CNT_EN)
module hazard_scheduler #(
  parameter int DELAY_SLOT = 0,
  parameter int WAIT_MAX   = 255,
  parameter int CNT_W      = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_use_rs,
  input  logic       id_use_rt,
  input  logic       id_branch,
  input  logic       id_take,
  input  logic       id_jump,
  input  logic       id_jreg,
  input  logic       ex_regwrite,
  input  logic       ex_memread,
  input  logic [4:0] ex_wreg,
  input  logic       mem_regwrite,
  input  logic       mem_memread,
  input  logic [4:0] mem_wreg,
  input  logic       dmem_req,
  input  logic       dmem_ready,
  output logic       pc_en,
  output logic       ifid_en,
  output logic       exmem_en,
  output logic       ifid_flush,
  output logic       idex_flush,
  output logic       memwb_bubble,
  output logic       mem_timeout,
  output logic [1:0] state
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0] perf_stall,
  output logic [31:0] perf_flush,
  output logic [31:0] perf_wait
`endif
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    RECOVER  = 2'd2
  } stateT;

  localparam logic [CNT_W-1:0] WAIT_TOP  = CNT_W'(WAIT_MAX);
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(WAIT_MAX - 1);

  stateT            curState;
  stateT            nextState;
  logic [CNT_W-1:0] waitCnt;
  logic             timeoutFlag;

  logic exMatch, exCtlMatch, memCtlMatch;
  logic isCtl, loadUse, ctlEx, ctlMem, dataStall, transfer;
  logic freeze, enterTimeout;

  // mem_regwrite carries no hazard on its own: only a load in MEM delays a branch compare
  logic unusedInputs;
  assign unusedInputs = mem_regwrite;

  // Operand-match and hazard detection; jr/jalr only depend on rs
  always_comb begin
    isCtl       = id_branch | id_jreg;
    exMatch     = (ex_wreg != 5'd0) &&
                  ((id_use_rs && ex_wreg == id_rs) || (id_use_rt && ex_wreg == id_rt));
    exCtlMatch  = id_jreg ? ((ex_wreg != 5'd0) && ex_wreg == id_rs) : exMatch;
    memCtlMatch = id_jreg ? ((mem_wreg != 5'd0) && mem_wreg == id_rs)
                          : ((mem_wreg != 5'd0) &&
                             ((id_use_rs && mem_wreg == id_rs) || (id_use_rt && mem_wreg == id_rt)));
    loadUse     = ex_memread & exMatch;
    ctlEx       = isCtl & ex_regwrite & exCtlMatch;
    ctlMem      = isCtl & mem_memread & memCtlMatch;
    dataStall   = loadUse | ctlEx | ctlMem;
    transfer    = ((id_branch & id_take) | id_jump) & ~dataStall;
  end

  // State register with async reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) curState <= RUN;
    else          curState <= nextState;
  end

  // Next-state and prioritised per-stage controls; reset forces NOPs into every register
  always_comb begin
    nextState    = curState;
    enterTimeout = 1'b0;
    freeze       = 1'b0;
    pc_en        = 1'b1;
    ifid_en      = 1'b1;
    exmem_en     = 1'b1;
    ifid_flush   = 1'b0;
    idex_flush   = 1'b0;
    memwb_bubble = 1'b0;

    case (curState)
      RUN:      if (dmem_req && !dmem_ready) nextState = MEM_WAIT;
      MEM_WAIT: begin
        if (dmem_ready) nextState = RUN;
        else if (waitCnt >= WAIT_LAST) begin
          nextState    = RECOVER;
          enterTimeout = 1'b1;
        end
      end
      RECOVER:  nextState = RUN;
      default:  nextState = RUN;
    endcase

    freeze = ((curState == RUN) && dmem_req && !dmem_ready) || (curState == MEM_WAIT);

    if (freeze) begin
      pc_en        = 1'b0;
      ifid_en      = 1'b0;
      exmem_en     = 1'b0;
      memwb_bubble = 1'b1;
    end else if (curState == RECOVER) begin
      pc_en        = 1'b0;
      ifid_en      = 1'b0;
      memwb_bubble = 1'b1;
    end else if (dataStall) begin
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      idex_flush = 1'b1;
    end else if (transfer && DELAY_SLOT == 0) begin
      ifid_flush = 1'b1;
    end

    if (!reset_n) begin
      pc_en        = 1'b0;
      ifid_en      = 1'b0;
      exmem_en     = 1'b0;
      ifid_flush   = 1'b1;
      idex_flush   = 1'b1;
      memwb_bubble = 1'b1;
    end
  end

  // Watchdog: counts consecutive MEM_WAIT cycles; the timeout flag is sticky until reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      waitCnt     <= '0;
      timeoutFlag <= 1'b0;
    end else begin
      if (curState == MEM_WAIT) begin
        if (waitCnt != WAIT_TOP) waitCnt <= waitCnt + 1'b1;
      end else begin
        waitCnt <= '0;
      end
      if (enterTimeout) timeoutFlag <= 1'b1;
    end
  end

  assign mem_timeout = timeoutFlag;
  assign state       = curState;

`ifdef HAZARD_PERF_CNT_EN
  logic stallCycle;
  assign stallCycle = dataStall & ~freeze & (curState != RECOVER);

  // Free-running wrap-around event counters
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perf_stall <= '0;
      perf_flush <= '0;
      perf_wait  <= '0;
    end else begin
      if (stallCycle) perf_stall <= perf_stall + 32'd1;
      if (ifid_flush) perf_flush <= perf_flush + 32'd1;
      if (freeze)     perf_wait  <= perf_wait + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_scheduler.sv
// tb/tb_hazard_scheduler.sv - directed table-driven bench for hazard_scheduler
module tb_hazard_scheduler;

  logic       clk;
  logic       reset_n;
  logic [4:0] id_rs, id_rt, ex_wreg, mem_wreg;
  logic       id_use_rs, id_use_rt, id_branch, id_take, id_jump, id_jreg;
  logic       ex_regwrite, ex_memread, mem_regwrite, mem_memread;
  logic       dmem_req, dmem_ready;
  logic       pc_en, ifid_en, exmem_en, ifid_flush, idex_flush, memwb_bubble, mem_timeout;
  logic [1:0] state;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] perf_stall, perf_flush, perf_wait;
`endif

  int checks;
  int errors;

  localparam logic [5:0] NORM   = 6'b111000;
  localparam logic [5:0] STALL  = 6'b001010;
  localparam logic [5:0] FLUSH  = 6'b111100;
  localparam logic [5:0] FREEZE = 6'b000001;
  localparam logic [5:0] RECOV  = 6'b001001;
  localparam logic [5:0] RSTOUT = 6'b000111;

  logic [5:0] outs;
  assign outs = {pc_en, ifid_en, exmem_en, ifid_flush, idex_flush, memwb_bubble};

  hazard_scheduler #(.DELAY_SLOT(0), .WAIT_MAX(4), .CNT_W(16)) dut (
    .clk(clk), .reset_n(reset_n),
    .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .id_branch(id_branch), .id_take(id_take), .id_jump(id_jump), .id_jreg(id_jreg),
    .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .ex_wreg(ex_wreg),
    .mem_regwrite(mem_regwrite), .mem_memread(mem_memread), .mem_wreg(mem_wreg),
    .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .pc_en(pc_en), .ifid_en(ifid_en), .exmem_en(exmem_en),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush), .memwb_bubble(memwb_bubble),
    .mem_timeout(mem_timeout), .state(state)
`ifdef HAZARD_PERF_CNT_EN
    , .perf_stall(perf_stall), .perf_flush(perf_flush), .perf_wait(perf_wait)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [4:0] rs, rt;
    logic       useRs, useRt, branch, take, jump, jreg;
    logic       exRw, exMr;
    logic [4:0] exW;
    logic       memRw, memMr;
    logic [4:0] memW;
    logic [5:0] exp;
  } vecT;

  function automatic vecT mkVec(string nm, logic [4:0] rs, logic [4:0] rt,
                                logic useRs, logic useRt, logic branch, logic take,
                                logic jump, logic jreg, logic exRw, logic exMr,
                                logic [4:0] exW, logic memRw, logic memMr,
                                logic [4:0] memW, logic [5:0] exp);
    vecT v;
    v.name = nm; v.rs = rs; v.rt = rt; v.useRs = useRs; v.useRt = useRt;
    v.branch = branch; v.take = take; v.jump = jump; v.jreg = jreg;
    v.exRw = exRw; v.exMr = exMr; v.exW = exW;
    v.memRw = memRw; v.memMr = memMr; v.memW = memW; v.exp = exp;
    return v;
  endfunction

  task automatic drive(input vecT v);
    id_rs = v.rs; id_rt = v.rt; id_use_rs = v.useRs; id_use_rt = v.useRt;
    id_branch = v.branch; id_take = v.take; id_jump = v.jump; id_jreg = v.jreg;
    ex_regwrite = v.exRw; ex_memread = v.exMr; ex_wreg = v.exW;
    mem_regwrite = v.memRw; mem_memread = v.memMr; mem_wreg = v.memW;
  endtask

  task automatic clearIn();
    id_rs = 0; id_rt = 0; id_use_rs = 0; id_use_rt = 0;
    id_branch = 0; id_take = 0; id_jump = 0; id_jreg = 0;
    ex_regwrite = 0; ex_memread = 0; ex_wreg = 0;
    mem_regwrite = 0; mem_memread = 0; mem_wreg = 0;
    dmem_req = 0; dmem_ready = 0;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  vecT vecs[15];
  vecT seq[3];

  initial begin
    checks = 0;
    errors = 0;
    clearIn();
    reset_n = 1'b0;

    vecs[0]  = mkVec("idle",          0,  0, 0,0, 0,0, 0,0, 0,0,  0, 0,0, 0, NORM);
    vecs[1]  = mkVec("lu_rs",         8,  9, 1,1, 0,0, 0,0, 1,1,  8, 0,0, 0, STALL);
    vecs[2]  = mkVec("lu_rt",         9,  8, 1,1, 0,0, 0,0, 1,1,  8, 0,0, 0, STALL);
    vecs[3]  = mkVec("lu_rt_unused",  9,  8, 1,0, 0,0, 0,0, 1,1,  8, 0,0, 0, NORM);
    vecs[4]  = mkVec("lu_r0",         0,  0, 1,1, 0,0, 0,0, 1,1,  0, 0,0, 0, NORM);
    vecs[5]  = mkVec("alu_fwd",       8,  9, 1,1, 0,0, 0,0, 1,0,  8, 0,0, 0, NORM);
    vecs[6]  = mkVec("br_ex",         8,  9, 1,1, 1,0, 0,0, 1,0,  8, 0,0, 0, STALL);
    vecs[7]  = mkVec("br_mem_load",   8,  9, 1,1, 1,0, 0,0, 0,0,  0, 1,1, 9, STALL);
    vecs[8]  = mkVec("br_mem_alu",    8,  9, 1,1, 1,0, 0,0, 0,0,  0, 1,0, 9, NORM);
    vecs[9]  = mkVec("br_taken",      8,  9, 1,1, 1,1, 0,0, 0,0,  0, 0,0, 0, FLUSH);
    vecs[10] = mkVec("br_taken_haz",  8,  9, 1,1, 1,1, 0,0, 1,0,  8, 0,0, 0, STALL);
    vecs[11] = mkVec("jump",          0,  0, 0,0, 0,0, 1,0, 0,0,  0, 0,0, 0, FLUSH);
    vecs[12] = mkVec("jr_ex",        31,  0, 1,0, 0,0, 1,1, 1,0, 31, 0,0, 0, STALL);
    vecs[13] = mkVec("br_not_taken",  8,  9, 1,1, 1,0, 0,0, 0,0,  0, 0,0, 0, NORM);
    vecs[14] = mkVec("lu_mem_only",   8,  9, 1,1, 0,0, 0,0, 0,0,  0, 1,1, 8, NORM);

    seq[0] = mkVec("lw_beq_c1", 8, 9, 1,1, 1,1, 0,0, 1,1, 8, 0,0, 0, STALL);
    seq[1] = mkVec("lw_beq_c2", 8, 9, 1,1, 1,1, 0,0, 0,0, 0, 1,1, 8, STALL);
    seq[2] = mkVec("lw_beq_c3", 8, 9, 1,1, 1,1, 0,0, 0,0, 0, 1,1, 0, FLUSH);

    #2;
    chk("rst_outs", 32'(outs), 32'(RSTOUT));
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_timeout", 32'(mem_timeout), 32'd0);
    nextCycle();
    reset_n = 1'b1;

    for (int i = 0; i < 15; i++) begin
      drive(vecs[i]);
      @(negedge clk);
      chk(vecs[i].name, 32'(outs), 32'(vecs[i].exp));
      chk({vecs[i].name, "_state"}, 32'(state), 32'd0);
      nextCycle();
    end

    for (int i = 0; i < 3; i++) begin
      drive(seq[i]);
      @(negedge clk);
      chk(seq[i].name, 32'(outs), 32'(seq[i].exp));
      nextCycle();
    end

    // Three-cycle memory wait, then completion
    clearIn();
    dmem_req = 1'b1;
    @(negedge clk);
    chk("mw_run_freeze", 32'(outs), 32'(FREEZE));
    chk("mw_run_state", 32'(state), 32'd0);
    for (int i = 0; i < 3; i++) begin
      nextCycle();
      if (i == 2) dmem_ready = 1'b1;
      @(negedge clk);
      chk("mw_state", 32'(state), 32'd1);
      chk("mw_outs", 32'(outs), 32'(FREEZE));
    end
    nextCycle();
    dmem_req = 1'b0;
    dmem_ready = 1'b0;
    @(negedge clk);
    chk("mw_back_state", 32'(state), 32'd0);
    chk("mw_back_outs", 32'(outs), 32'(NORM));
    chk("mw_no_timeout", 32'(mem_timeout), 32'd0);

    // Watchdog expiry with WAIT_MAX=4
    nextCycle();
    dmem_req = 1'b1;
    @(negedge clk);
    chk("wd_run_state", 32'(state), 32'd0);
    for (int i = 0; i < 4; i++) begin
      nextCycle();
      @(negedge clk);
      chk("wd_wait_state", 32'(state), 32'd1);
      chk("wd_wait_timeout", 32'(mem_timeout), 32'd0);
    end
    nextCycle();
    dmem_req = 1'b0;
    @(negedge clk);
    chk("wd_recover_state", 32'(state), 32'd2);
    chk("wd_recover_outs", 32'(outs), 32'(RECOV));
    chk("wd_timeout_set", 32'(mem_timeout), 32'd1);
    nextCycle();
    @(negedge clk);
    chk("wd_run_again", 32'(state), 32'd0);
    chk("wd_run_outs", 32'(outs), 32'(NORM));
    chk("wd_timeout_sticky", 32'(mem_timeout), 32'd1);

    // Asynchronous reset in the middle of a memory wait
    nextCycle();
    dmem_req = 1'b1;
    nextCycle();
    @(negedge clk);
    chk("ar_pre_state", 32'(state), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("ar_outs", 32'(outs), 32'(RSTOUT));
    chk("ar_state", 32'(state), 32'd0);
    chk("ar_timeout", 32'(mem_timeout), 32'd0);
`ifdef HAZARD_PERF_CNT_EN
    chk("ar_perf_stall", perf_stall, 32'd0);
    chk("ar_perf_flush", perf_flush, 32'd0);
    chk("ar_perf_wait", perf_wait, 32'd0);
`endif
    nextCycle();
    reset_n = 1'b1;
    dmem_req = 1'b0;
    @(negedge clk);
    chk("ar_release_state", 32'(state), 32'd0);
    chk("ar_release_outs", 32'(outs), 32'(NORM));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
